// File: rtl/key_led_mode_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : key_led_mode_ctrl                                        |
// | Description : Push-button LED mode controller. Synchronises and        |
// |               debounces a raw key, emits one pulse per accepted press  |
// |               and steps OFF -> ON -> SLOW blink -> FAST blink -> OFF.  |
// | Ports       : sys_clk   - system clock                                 |
// |               sys_rst_n - asynchronous active-low reset                |
// |               key_input - raw key pin (0 = pressed)                    |
// |               led_out   - LED drive, active-low (0 = lit)              |
// |               mode      - 00 OFF, 01 ON, 10 SLOW, 11 FAST              |
// |               key_flag  - one-cycle pulse per accepted press           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module key_led_mode_ctrl #(
  parameter int CNT_DEBOUNCE = 999_999,
  parameter int BLINK_SLOW   = 24_999_999,
  parameter int BLINK_FAST   = 4_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_input,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       key_flag
);

  // One shared counter width, wide enough to hold the largest parameter.
  localparam int MAX_P_A = (CNT_DEBOUNCE > BLINK_SLOW) ? CNT_DEBOUNCE : BLINK_SLOW;
  localparam int MAX_P   = (MAX_P_A > BLINK_FAST) ? MAX_P_A : BLINK_FAST;
  localparam int CW      = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] C_DEB_MAX   = CW'(CNT_DEBOUNCE);
  localparam logic [CW-1:0] C_DEB_ARM   = CW'(CNT_DEBOUNCE - 1);
  localparam logic [CW-1:0] C_SLOW_LAST = CW'(BLINK_SLOW - 1);
  localparam logic [CW-1:0] C_FAST_LAST = CW'(BLINK_FAST - 1);
  localparam logic [CW-1:0] C_ONE       = CW'(1);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_ON   = 2'b01,
    MODE_SLOW = 2'b10,
    MODE_FAST = 2'b11
  } mode_e;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic          key_flag_q, key_flag_d;
  mode_e         mode_q, mode_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          led_q, led_d;
  logic [CW-1:0] half_last;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      deb_cnt_q   <= '0;
      key_flag_q  <= 1'b0;
      mode_q      <= MODE_OFF;
      blink_cnt_q <= '0;
      led_q       <= 1'b1;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_cnt_q   <= deb_cnt_d;
      key_flag_q  <= key_flag_d;
      mode_q      <= mode_d;
      blink_cnt_q <= blink_cnt_d;
      led_q       <= led_d;
    end
  end

  // Synchroniser and debounce. The count saturates so that a long hold
  // passes through the arm value only once and therefore pulses only once.
  always_comb begin
    sync1_d = key_input;
    sync2_d = sync1_q;
    if (sync2_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != C_DEB_MAX) begin
      deb_cnt_d = deb_cnt_q + C_ONE;
    end else begin
      deb_cnt_d = deb_cnt_q;
    end
    key_flag_d = !sync2_q && (deb_cnt_q == C_DEB_ARM);
  end

  // Mode FSM and blink generator. A press wins over a blink toggle.
  always_comb begin
    mode_d      = mode_q;
    blink_cnt_d = blink_cnt_q;
    led_d       = led_q;
    half_last   = (mode_q == MODE_SLOW) ? C_SLOW_LAST : C_FAST_LAST;

    if (key_flag_q) begin
      unique case (mode_q)
        MODE_OFF:  mode_d = MODE_ON;
        MODE_ON:   mode_d = MODE_SLOW;
        MODE_SLOW: mode_d = MODE_FAST;
        MODE_FAST: mode_d = MODE_OFF;
        default:   mode_d = MODE_OFF;
      endcase
      blink_cnt_d = '0;
      led_d       = (mode_d == MODE_OFF);
    end else begin
      unique case (mode_q)
        MODE_OFF: begin
          blink_cnt_d = '0;
          led_d       = 1'b1;
        end
        MODE_ON: begin
          blink_cnt_d = '0;
          led_d       = 1'b0;
        end
        MODE_SLOW, MODE_FAST: begin
          if (blink_cnt_q == half_last) begin
            blink_cnt_d = '0;
            led_d       = !led_q;
          end else begin
            blink_cnt_d = blink_cnt_q + C_ONE;
          end
        end
        default: begin
          blink_cnt_d = '0;
          led_d       = 1'b1;
        end
      endcase
    end
  end

  assign led_out  = led_q;
  assign mode     = mode_q;
  assign key_flag = key_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_key_led_mode_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_key_led_mode_ctrl                                     |
// | Description : Self-checking bench for key_led_mode_ctrl. A reference   |
// |               model predicts every cycle's outputs into a queue that   |
// |               is popped and compared on the falling edge; directed     |
// |               steps add timing, blink-pattern and collision checks.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_key_led_mode_ctrl;

  localparam int CNT = 4;
  localparam int SLW = 7;
  localparam int FST = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_input = 1'b1;
  logic       led_out;
  logic [1:0] mode;
  logic       key_flag;

  key_led_mode_ctrl #(.CNT_DEBOUNCE(CNT), .BLINK_SLOW(SLW), .BLINK_FAST(FST)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .key_input(key_input),
    .led_out  (led_out),
    .mode     (mode),
    .key_flag (key_flag)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int flag_cnt = 0;
  int last_flag_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model. The flag is predicted from input history: a run of
  // exactly CNT low samples ending at edge s yields a pulse after edge s+2.
  logic [3:0] sb[$];
  int         run = 0;
  logic [1:0] hist = 2'b00;
  logic       m_flag = 1'b0;
  logic [1:0] m_mode = 2'd0;
  logic       m_led = 1'b1;
  int         m_ph = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run = 0; hist = 2'b00; m_flag = 1'b0; m_mode = 2'd0; m_led = 1'b1; m_ph = 0;
      sb.delete();
    end else begin
      logic hit, flag_now;
      int   half;
      if (key_input) run = 0;
      else if (run < CNT + 8) run++;
      hit      = (run == CNT);
      flag_now = hist[1];
      hist     = {hist[0], hit};
      if (m_flag) begin
        m_mode = m_mode + 2'd1;
        m_ph   = 0;
        m_led  = (m_mode == 2'd0);
      end else if (m_mode >= 2'd2) begin
        half = (m_mode == 2'd2) ? SLW : FST;
        if (m_ph == half - 1) begin
          m_ph  = 0;
          m_led = ~m_led;
        end else begin
          m_ph++;
        end
      end
      m_flag = flag_now;
      sb.push_back({m_flag, m_mode, m_led});
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst_n) begin
      chk("rst_led", 32'(led_out), 32'd1);
      chk("rst_mode", 32'(mode), 32'd0);
      chk("rst_flag", 32'(key_flag), 32'd0);
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("sb_flag", 32'(key_flag), 32'(e[3]));
      chk("sb_mode", 32'(mode), 32'(e[2:1]));
      chk("sb_led", 32'(led_out), 32'(e[0]));
    end
    if (rst_n && key_flag === 1'b1) begin
      flag_cnt++;
      last_flag_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Hold the key low until the model reports the target mode, then check the
  // LED pattern for nsamp cycles (half==0 means a steady level).
  task automatic press_to(input logic [1:0] target, input int nsamp, input int half);
    int  g;
    logic expv;
    key_input = 1'b0;
    g = 0;
    while (m_mode != target && g < 20) begin
      tick();
      g++;
    end
    chk("press_reach", 32'(mode), 32'(target));
    for (int i = 0; i < nsamp; i++) begin
      if (half == 0) expv = (target == 2'd0);
      else expv = ((i / half) % 2) == 1;
      chk("blink_pattern", 32'(led_out), 32'(expv));
      tick();
    end
  endtask

  initial begin
    int k, f0, g, r;

    // Reset with key toggling.
    tick(); key_input = 1'b0;
    tick(); key_input = 1'b1;
    tick(); rst_n = 1'b1;
    idle(3);

    // Clean press held for 20 clocks.
    f0 = flag_cnt;
    key_input = 1'b0;
    k = cyc + 1;
    idle(20);
    chk("clean_count", 32'(flag_cnt - f0), 32'd1);
    chk("clean_edge", 32'(last_flag_cyc), 32'(k + 5));
    chk("clean_mode", 32'(mode), 32'd1);
    chk("clean_led", 32'(led_out), 32'd0);
    key_input = 1'b1;
    idle(8);

    // Bounce: 0x3, 1x1, 0x3, release.
    f0 = flag_cnt;
    key_input = 1'b0; idle(3);
    key_input = 1'b1; idle(1);
    key_input = 1'b0; idle(3);
    key_input = 1'b1; idle(8);
    chk("bounce_count", 32'(flag_cnt - f0), 32'd0);
    chk("bounce_mode", 32'(mode), 32'd1);

    // Random key activity, checked cycle by cycle by the scoreboard.
    for (int i = 0; i < 300; i++) begin
      key_input = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      tick();
    end
    key_input = 1'b1;
    idle(10);
    for (int i = 0; i < 4 && m_mode != 2'd0; i++) begin
      press_to(m_mode + 2'd1, 0, 0);
      key_input = 1'b1;
      idle(4);
    end

    // Mode cycle with blink pattern checks.
    press_to(2'd1, 8, 0);  key_input = 1'b1; idle(4);
    press_to(2'd2, 28, SLW); key_input = 1'b1; idle(4);
    press_to(2'd3, 12, FST); key_input = 1'b1; idle(4);
    press_to(2'd0, 8, 0);  key_input = 1'b1; idle(4);

    // Collision: flag lands on the SLOW toggle cycle.
    press_to(2'd1, 0, 0); key_input = 1'b1; idle(4);
    press_to(2'd2, 0, 0); key_input = 1'b1;
    tick();
    g = 0;
    while (!(m_mode == 2'd2 && m_ph == 0) && g < 20) begin tick(); g++; end
    chk("coll_align", 32'(g < 20), 32'd1);
    f0 = flag_cnt;
    key_input = 1'b0;
    g = 0;
    while (flag_cnt == f0 && g < 12) begin tick(); g++; end
    chk("coll_flag", 32'(flag_cnt - f0), 32'd1);
    chk("coll_cnt_pre", 32'(dut.blink_cnt_q), 32'(SLW - 1));
    chk("coll_mode_pre", 32'(mode), 32'd2);
    tick();
    chk("coll_mode", 32'(mode), 32'd3);
    chk("coll_led", 32'(led_out), 32'd0);
    chk("coll_cnt", 32'(dut.blink_cnt_q), 32'd0);

    // Reset during FAST with the key still held.
    idle(2);
    rst_n = 1'b0;
    idle(2);
    f0 = flag_cnt;
    rst_n = 1'b1;
    r = cyc + 1;
    g = 0;
    while (flag_cnt == f0 && g < 12) begin tick(); g++; end
    chk("rst_hold_flag", 32'(flag_cnt - f0), 32'd1);
    chk("rst_hold_edge", 32'(last_flag_cyc), 32'(r + 5));
    tick();
    chk("rst_hold_mode", 32'(mode), 32'd1);
    idle(10);
    chk("rst_hold_once", 32'(flag_cnt - f0), 32'd1);
    key_input = 1'b1;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
